// File: rtl/regfile_nrd_if.sv
// Register file port bundle: write port, NRD read ports, clear request and busy.
interface regfile_nrd_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                 we;
  logic [AW-1:0]        wa;
  logic [WIDTH-1:0]     wd;
  logic [NRD*AW-1:0]    ra;
  logic [NRD*WIDTH-1:0] rd;
  logic                 clr_start;
  logic                 busy;

  modport master (output we, wa, wd, ra, clr_start, input rd, busy);
  modport slave  (input we, wa, wd, ra, clr_start, output rd, busy);
endinterface

// File: rtl/regfile_nrd.sv
// Parametrised register file: NRD read ports, one write port with bypass,
// optional hard-wired zero register, registered or combinational reads, and
// a one-entry-per-cycle clear engine.

// One read port: resolves the read value from busy, range, zero register,
// write bypass and the stored word, in that priority.
module regfile_nrd_rport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic             busy,
  input  logic             wr_acc,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra,
  input  logic [WIDTH-1:0] mem_val,
  output logic [WIDTH-1:0] rval
);
  logic in_range;
  assign in_range = {1'b0, ra} < (AW+1)'(DEPTH);

  // priority chain for the read value
  always_comb begin
    rval = '0;
    if (busy || !in_range)                   rval = '0;
    else if (ZERO_REG != 0 && ra == '0)      rval = '0;
    else if (wr_acc && wa == ra)             rval = wd;
    else                                     rval = mem_val;
  end
endmodule

module regfile_nrd #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int RD_REG   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_nrd_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [WIDTH-1:0]          mem_d [DEPTH];
  logic                      busy, wr_acc;
  logic [NRD-1:0][WIDTH-1:0] mem_val, rval;

  assign busy     = (state_q == CLEAR);
  assign bus.busy = busy;
  assign wr_acc   = bus.we && !busy && ({1'b0, bus.wa} < (AW+1)'(DEPTH)) &&
                    !(ZERO_REG != 0 && bus.wa == '0);

  // clear sequencer and write port: IDLE takes writes, CLEAR zeroes one entry per cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (wr_acc) mem_d[bus.wa] = bus.wd;
        if (bus.clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        mem_d[cnt_q] = '0;
        if (cnt_q == AW'(DEPTH-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counter and array registers; reset wipes everything, even mid-clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [AW-1:0] ra_k;
    assign ra_k = bus.ra[k*AW +: AW];

    // out-of-range addresses are masked by the port itself
    always_comb begin
      mem_val[k] = '0;
      if ({1'b0, ra_k} < (AW+1)'(DEPTH)) mem_val[k] = mem_q[ra_k];
    end

    regfile_nrd_rport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_rport (
      .busy    (busy),
      .wr_acc  (wr_acc),
      .wa      (bus.wa),
      .wd      (bus.wd),
      .ra      (ra_k),
      .mem_val (mem_val[k]),
      .rval    (rval[k])
    );
  end

  if (RD_REG != 0) begin : g_rdreg
    logic [NRD-1:0][WIDTH-1:0] rd_q, rd_d;
    always_comb rd_d = rval;
    // registered read data, one cycle behind the address
    always_ff @(posedge clk) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= rd_d;
    end
    assign bus.rd = rd_q;
  end else begin : g_rdcomb
    assign bus.rd = rval;
  end
endmodule

// File: tb/tb_regfile_nrd.sv
// Bench for regfile_nrd: two configurations driven by the same stimulus.
//  A: 32x32, 2 ports, zero register, registered reads.
//  B: 20x16, 4 ports, no zero register, combinational reads.
module tb_regfile_nrd;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_nrd_if #(.WIDTH(32), .DEPTH(32), .NRD(2)) ifa ();
  regfile_nrd_if #(.WIDTH(16), .DEPTH(20), .NRD(4)) ifb ();

  regfile_nrd #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .RD_REG(1)) ua (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  regfile_nrd #(.WIDTH(16), .DEPTH(20), .NRD(4), .ZERO_REG(0), .RD_REG(0)) ub (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  typedef struct {
    int          due;
    logic [63:0] rd;
    logic        busy;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // stimulus globals
  bit          g_we, g_clr, g_rst;
  int          g_wa;
  logic [31:0] g_wd;
  int          g_ra [4];

  // reference state: plain arrays plus "cycles of clearing left"
  logic [31:0] ma [32];
  logic [15:0] mb [20];
  int          cla = 0, clb = 0;

  task automatic model_push();
    ent_t        e;
    bit          bsy, acc;
    logic [31:0] v;
    int          r;
    // config A: result seen after the next edge
    e.due = cyc + 1;
    e.rd  = '0;
    if (g_rst) begin
      foreach (ma[i]) ma[i] = '0;
      cla = 0;
    end else begin
      bsy = (cla > 0);
      acc = g_we && !bsy && g_wa != 0 && g_wa < 32;
      for (int k = 0; k < 2; k++) begin
        r = g_ra[k];
        v = '0;
        if (!bsy && r != 0 && r < 32) v = (acc && g_wa == r) ? g_wd : ma[r];
        e.rd[k*32 +: 32] = v;
      end
      if (bsy) begin
        ma[32 - cla] = '0;
        cla--;
      end else begin
        if (acc) ma[g_wa] = g_wd;
        if (g_clr) cla = 32;
      end
    end
    e.busy = (cla > 0);
    qa.push_back(e);
    // config B: result seen in the same cycle
    if (g_rst) begin
      foreach (mb[i]) mb[i] = '0;
      clb = 0;
    end else begin
      e.due  = cyc;
      e.rd   = '0;
      bsy    = (clb > 0);
      e.busy = bsy;
      acc    = g_we && !bsy && g_wa < 20;
      for (int k = 0; k < 4; k++) begin
        r = g_ra[k];
        v = '0;
        if (!bsy && r < 20) v = (acc && g_wa == r) ? {16'h0, g_wd[15:0]} : {16'h0, mb[r]};
        e.rd[k*16 +: 16] = v[15:0];
      end
      qb.push_back(e);
      if (bsy) begin
        mb[20 - clb] = '0;
        clb--;
      end else begin
        if (acc) mb[g_wa] = g_wd[15:0];
        if (g_clr) clb = 20;
      end
    end
  endtask

  task automatic op(bit w, int a, logic [31:0] d, int r0, int r1, int r2, int r3,
                    bit c = 1'b0, bit rs = 1'b0);
    @(posedge clk);
    #1;
    g_we = w; g_wa = a; g_wd = d; g_clr = c; g_rst = rs;
    g_ra[0] = r0; g_ra[1] = r1; g_ra[2] = r2; g_ra[3] = r3;
    rst_n         = ~rs;
    ifa.we        = w;  ifb.we        = w;
    ifa.wa        = 5'(a); ifb.wa     = 5'(a);
    ifa.wd        = d;  ifb.wd        = d[15:0];
    ifa.clr_start = c;  ifb.clr_start = c;
    ifa.ra        = {5'(r1), 5'(r0)};
    ifb.ra        = {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
    model_push();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) op(0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: compare whatever is due this cycle
  always @(negedge clk) begin
    ent_t e;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      e = qa.pop_front();
      tests += 2;
      if (e.due != cyc || ifa.rd !== e.rd) begin
        fails++;
        $display("FAIL rd_a cyc=%0d got %h exp %h", cyc, ifa.rd, e.rd);
      end
      if (ifa.busy !== e.busy) begin
        fails++;
        $display("FAIL busy_a cyc=%0d got %b exp %b", cyc, ifa.busy, e.busy);
      end
    end
    while (qb.size() > 0 && qb[0].due <= cyc) begin
      e = qb.pop_front();
      tests += 2;
      if (e.due != cyc || ifb.rd !== e.rd) begin
        fails++;
        $display("FAIL rd_b cyc=%0d got %h exp %h", cyc, ifb.rd, e.rd);
      end
      if (ifb.busy !== e.busy) begin
        fails++;
        $display("FAIL busy_b cyc=%0d got %b exp %b", cyc, ifb.busy, e.busy);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    // reset, then every address reads 0
    op(0, 0, 0, 0, 0, 0, 0, 0, 1);
    op(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) op(0, 0, 0, i, 31 - i, (i + 7) % 32, (i + 13) % 32);
    // basic write then read on both ports
    op(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    op(0, 0, 0, 5, 5, 5, 5);
    // zero register and out-of-range
    op(1, 0, 32'h1234, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0, 0);
    op(1, 25, 32'h5555AAAA, 25, 25, 25, 5);
    op(0, 0, 0, 25, 0, 19, 25);
    // bypass
    op(1, 3, 32'h11, 0, 0, 0, 0);
    op(1, 7, 32'hA5A5A5A5, 7, 3, 7, 3);
    op(0, 0, 0, 7, 3, 3, 7);
    // fill, clear, writes during busy are ignored, then everything reads 0
    for (int i = 0; i < 32; i++) op(1, i, i + 1, i, 0, i, 0);
    op(0, 0, 0, 1, 2, 1, 2, 1);
    for (int i = 0; i < 34; i++) op(1, i % 32, 32'hF000 + i, i % 32, 5, i % 20, 9, i % 3 == 0);
    for (int i = 0; i < 32; i++) op(0, 0, 0, i, (i + 1) % 32, i, (i + 19) % 32);
    // write collides with clear request
    op(1, 4, 32'h44, 0, 0, 0, 0);
    op(1, 9, 32'h99, 9, 4, 9, 4, 1);
    idle(33);
    op(0, 0, 0, 9, 4, 9, 4);
    // reset mid-clear
    for (int i = 1; i < 20; i++) op(1, i, 32'h300 + i, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0, 0, 1);
    idle(9);
    op(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) op(0, 0, 0, i, i, i % 20, (i + 5) % 20);
    // distinct values on distinct ports
    op(1, 2, 32'h0000A002, 0, 0, 0, 0);
    op(1, 9, 32'h0000B009, 0, 0, 0, 0);
    op(1, 13, 32'h0000C00D, 0, 0, 0, 0);
    op(1, 17, 32'h0000D011, 0, 0, 0, 0);
    op(0, 0, 0, 2, 9, 13, 17);
    op(0, 0, 0, 17, 13, 9, 2);
    // randomized traffic
    for (int i = 0; i < 500; i++)
      op($urandom_range(0, 2) != 0, $urandom_range(0, 31), $urandom,
         $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 59) == 0, $urandom_range(0, 199) == 0);
    idle(3);
    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d/%0d pending exp 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
